// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared CPU definitions used by the fetch stage and the Q1/Q2 pipeline
// register: datapath width, the canonical NOP, the fetch FSM encoding, the
// fetch-buffer entry layout and a word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- also the reset value of the Q1/Q2 instruction register.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,  // ready to issue a request at fetch_pc
    FETCH_WAIT  = 2'd1,  // request accepted, response pending
    FETCH_DRAIN = 2'd2   // response pending but already invalidated by a redirect
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_incr;
  } fetch_entry_t;

  // Instruction fetches are word aligned; the low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// One-entry holding register between instruction memory and decode. Outputs
// come straight from the register. An empty entry drives NOP_INSTR while the
// PC fields keep their last values.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load_i        capture entry_i (a response for the current fetch)
//   flush_i       discard the entry (redirect); wins over load and consume
//   stall_i       decode not accepting; a valid entry is held
//   entry_i       {instr, pc, pc_incr} to capture
//   valid_o       entry holds a valid fetch
//   entry_o       current entry (instr = NOP_INSTR when !valid_o)
// -----------------------------------------------------------------------------
module fetch_buf #(
  parameter logic [fetch_unit_pkg::XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        flush_i,
  input  logic                        stall_i,
  input  fetch_unit_pkg::fetch_entry_t entry_i,
  output logic                        valid_o,
  output fetch_unit_pkg::fetch_entry_t entry_o
);
  import fetch_unit_pkg::*;

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;
  logic         consume;

  // The entry leaves whenever decode takes it.
  assign consume = valid_q && !stall_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d       = 1'b0;
      entry_d.instr = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (consume) begin
      valid_d       = 1'b0;
      entry_d.instr = NOP_INSTR;
    end
  end

  // NOTE: the single-entry register is control-visible output state, so it is
  // reset to a defined NOP/zero value rather than left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '{instr: NOP_INSTR, pc: '0, pc_incr: '0};
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Q1 instruction fetch. Keeps the fetch PC, issues one word read at a time to
// instruction memory, and presents the fetched instruction with its PC and
// PC+4 to decode through a one-entry buffer. A redirect discards both the
// buffered instruction and any response still in flight.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req_valid/ready/addr  request channel (addr = fetch PC)
//   imem_rsp_valid/data        response channel, never backpressured
//   stall                      decode holding; outputs frozen
//   redirect, redirect_pc      taken branch/jump target
//   fetch_valid                outputs carry a valid fetch
//   instr_op, pc_op, pc_incr_op  instruction, its address, address + 4
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [fetch_unit_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [fetch_unit_pkg::XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [fetch_unit_pkg::XLEN-1:0] imem_req_addr,
  input  logic                            imem_rsp_valid,
  input  logic [fetch_unit_pkg::XLEN-1:0] imem_rsp_data,
  input  logic                            stall,
  input  logic                            redirect,
  input  logic [fetch_unit_pkg::XLEN-1:0] redirect_pc,
  output logic                            fetch_valid,
  output logic [fetch_unit_pkg::XLEN-1:0] instr_op,
  output logic [fetch_unit_pkg::XLEN-1:0] pc_op,
  output logic [fetch_unit_pkg::XLEN-1:0] pc_incr_op
);
  import fetch_unit_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fetch_pc_incr;
  logic [XLEN-1:0] redirect_target;
  logic            buf_valid;
  logic            buf_load;
  logic            can_issue;
  logic            handshake;
  fetch_entry_t    load_entry, buf_entry;

  // Only issue when the buffer will be free by the time the response lands:
  // either it is empty or decode takes it this cycle. This is why a response
  // never meets a full buffer.
  assign can_issue       = !buf_valid || !stall;
  assign imem_req_valid  = !rst && (state_q == FETCH_REQ) && can_issue;
  assign imem_req_addr   = fetch_pc_q;
  assign handshake       = imem_req_valid && imem_req_ready;
  assign fetch_pc_incr   = fetch_pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect_target = word_align(redirect_pc);
  assign load_entry      = '{instr: imem_rsp_data, pc: fetch_pc_q, pc_incr: fetch_pc_incr};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    buf_load   = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_target;
          // An accepted request for the old PC must still have its response drained.
          if (handshake) state_d = FETCH_DRAIN;
        end else if (handshake) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = FETCH_REQ;
          if (redirect) begin
            fetch_pc_d = redirect_target;
          end else begin
            fetch_pc_d = fetch_pc_incr;
            buf_load   = 1'b1;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_target;
          state_d    = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (redirect)       fetch_pc_d = redirect_target;
        if (imem_rsp_valid) state_d    = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_buf #(
    .NOP_INSTR (NOP_INSTR)
  ) u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .flush_i (redirect),
    .stall_i (stall),
    .entry_i (load_entry),
    .valid_o (buf_valid),
    .entry_o (buf_entry)
  );

  assign fetch_valid = buf_valid;
  assign instr_op    = buf_entry.instr;
  assign pc_op       = buf_entry.pc;
  assign pc_incr_op  = buf_entry.pc_incr;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The bench plays the instruction memory by
// hand: it drives imem_rsp_* one cycle after each accepted request. Inputs
// change 1 ns after the rising edge; outputs are sampled 1-2 ns after it.
// A second instance starts at 32'hFFFF_FFFC to cover PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] PATT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;

  // Main instance (RESET_PC = 0)
  logic        req_valid, ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        fv;
  logic [31:0] instr, pc, pc_incr;

  // Wrap instance (RESET_PC = 32'hFFFF_FFFC)
  logic        w_req_valid, w_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_stall, w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_fv;
  logic [31:0] w_instr, w_pc, w_pc_incr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fv),
    .instr_op       (instr),
    .pc_op          (pc),
    .pc_incr_op     (pc_incr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .stall          (w_stall),
    .redirect       (w_redirect),
    .redirect_pc    (w_redirect_pc),
    .fetch_valid    (w_fv),
    .instr_op       (w_instr),
    .pc_op          (w_pc),
    .pc_incr_op     (w_pc_incr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic [31:0] pi);
    check({tag, ".fetch_valid"}, {31'd0, fv}, {31'd0, v});
    check({tag, ".instr_op"},    instr,       i);
    check({tag, ".pc_op"},       pc,          p);
    check({tag, ".pc_incr_op"},  pc_incr,     pi);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] a);
    check({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, v});
    if (v) check({tag, ".req_addr"}, req_addr, a);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

    // Reset state
    #1;
    check_out("reset", 1'b0, NOP, 32'h0, 32'h0);
    check_req("reset", 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_req("first_req", 1'b1, 32'h0);

    // 0-wait fetch of pc 0: response one cycle after the request
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h0 ^ PATT;
    #1 check_req("wait0", 1'b0, 32'h0);
    check_out("latency_bubble", 1'b0, NOP, 32'h0, 32'h0);
    tick();
    rsp_valid = 1'b0;
    check_out("fetch0", 1'b1, 32'hA5A5_0000, 32'h0, 32'h4);

    // Stall for 5 cycles: outputs frozen, no request issued
    stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_out("stall_hold", 1'b1, 32'hA5A5_0000, 32'h0, 32'h4);
      check_req("stall_noreq", 1'b0, 32'h0);
      tick();
    end
    stall = 1'b0;
    #1 check_req("unstall_req", 1'b1, 32'h4);

    tick();  // consume pc 0 and hand off request for pc 4
    rsp_valid = 1'b1; rsp_data = 32'h4 ^ PATT;
    check_out("consumed0", 1'b0, NOP, 32'h0, 32'h4);
    #1 check_req("wait4", 1'b0, 32'h0);
    tick();
    rsp_valid = 1'b0;
    check_out("fetch4", 1'b1, 32'hA5A5_0004, 32'h4, 32'h8);
    #1 check_req("req8", 1'b1, 32'h8);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h8 ^ PATT;
    check_out("bubble48", 1'b0, NOP, 32'h4, 32'h8);
    tick();
    rsp_valid = 1'b0;
    check_out("fetch8", 1'b1, 32'hA5A5_0008, 32'h8, 32'hC);

    // Memory not ready for 3 cycles: request held stable, handshake on the 4th
    ready = 1'b0;
    #1 check_req("notready0", 1'b1, 32'hC);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_req("notready", 1'b1, 32'hC);
    end
    tick();
    ready = 1'b1;
    #1 check_req("ready4th", 1'b1, 32'hC);
    tick();
    check_req("no_dup_req", 1'b0, 32'h0);

    // Redirect to 0x103 while in WAIT; stale response two cycles later
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    #1 check_req("drain0", 1'b0, 32'h0);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    #1 check_req("drain1", 1'b0, 32'h0);
    tick();
    rsp_valid = 1'b0;
    check_out("stale_dropped", 1'b0, NOP, 32'h8, 32'hC);
    #1 check_req("redir_req", 1'b1, 32'h100);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h100 ^ PATT;
    tick();
    rsp_valid = 1'b0;
    check_out("fetch100", 1'b1, 32'hA5A5_0100, 32'h100, 32'h104);

    // Redirect with stall=1 holding a valid buffer and rsp_valid high
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_BAD0;
    #1 check_req("stall_full", 1'b0, 32'h0);
    tick();
    redirect = 1'b0; rsp_valid = 1'b0;
    check_out("flush_stalled", 1'b0, NOP, 32'h100, 32'h104);
    #1 check_req("req200", 1'b1, 32'h200);

    // Redirect coincident with the response in WAIT, stall high
    tick();
    rsp_valid = 1'b1; rsp_data = 32'hBAD1_BAD1;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    rsp_valid = 1'b0; redirect = 1'b0; stall = 1'b0;
    check_out("rsp_redir", 1'b0, NOP, 32'h100, 32'h104);
    #1 check_req("req300", 1'b1, 32'h300);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h300 ^ PATT;
    tick();
    rsp_valid = 1'b0;
    check_out("fetch300", 1'b1, 32'hA5A5_0300, 32'h300, 32'h304);
    tick();  // consume; request for 0x304 accepted, now in WAIT
    check_out("consumed300", 1'b0, NOP, 32'h300, 32'h304);

    // Asynchronous reset while in WAIT, between clock edges
    #1 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, NOP, 32'h0, 32'h0);
    check_req("async_rst", 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1 check_req("post_rst", 1'b1, 32'h0);

    // Wrap instance: fetch at 0xFFFF_FFFC, next address wraps to 0
    w_ready = 1'b1;
    #1;
    check({"wrap.req_valid"}, {31'd0, w_req_valid}, 32'd1);
    check({"wrap.req_addr"}, w_req_addr, 32'hFFFF_FFFC);
    tick();
    w_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = 32'h1234_5678;
    tick();
    w_rsp_valid = 1'b0;
    check("wrap.fetch_valid", {31'd0, w_fv}, 32'd1);
    check("wrap.instr_op", w_instr, 32'h1234_5678);
    check("wrap.pc_op", w_pc, 32'hFFFF_FFFC);
    check("wrap.pc_incr_op", w_pc_incr, 32'h0);
    #1;
    check("wrap.next_req_valid", {31'd0, w_req_valid}, 32'd1);
    check("wrap.next_req_addr", w_req_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage (Q1) that produces the instruction, PC and PC+4 captured by the Q1/Q2 pipeline register.
- Holds the architectural fetch PC and issues word reads to instruction memory over a valid/ready request channel with an unbackpressured response channel.
- Holds one fetched instruction in an output buffer while the decode stage stalls.
- Discards in-flight fetches on a control-flow redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr_op when no valid fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request (= fetch_pc)
- imem_rsp_valid  in  1  read data valid; cannot be backpressured
- imem_rsp_data  in  32  instruction word
- stall  in  1  decode stage not accepting; hold outputs
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch target
- fetch_valid  out  1  instr_op/pc_op/pc_incr_op hold a valid fetch
- instr_op  out  32  fetched instruction, NOP_INSTR when !fetch_valid
- pc_op  out  32  address of instr_op
- pc_incr_op  out  32  pc_op + 4

Behaviour:
- Reset (async, rst=1): state=REQ, fetch_pc=RESET_PC, buffer empty. fetch_valid=0, instr_op=NOP_INSTR, pc_op=0, pc_incr_op=0, imem_req_valid=0 while rst is high.
- At most one outstanding memory request. Output buffer depth is 1. Outputs are registered straight from the buffer.
- Consume rule: the buffer is consumed on any cycle with fetch_valid=1 and stall=0. With stall=1, all outputs hold unchanged.
- can_issue = !buf_valid || !stall.
- State REQ:
  - imem_req_valid = can_issue; imem_req_addr = fetch_pc.
  - Handshake (valid & ready), no redirect -> WAIT.
  - Handshake with redirect in the same cycle -> DRAIN; fetch_pc <= redirect_pc.
  - No handshake with redirect -> stay REQ; fetch_pc <= redirect_pc.
- State WAIT:
  - imem_req_valid=0.
  - rsp_valid, no redirect: buffer <= {rsp_data, fetch_pc, fetch_pc+4}; fetch_pc <= fetch_pc+4; -> REQ.
  - rsp_valid with redirect: discard data; fetch_pc <= redirect_pc; -> REQ.
  - Redirect without rsp_valid: fetch_pc <= redirect_pc; -> DRAIN.
- State DRAIN:
  - imem_req_valid=0.
  - rsp_valid: discard -> REQ.
  - Redirect in DRAIN: fetch_pc <= redirect_pc; stay DRAIN, or go to REQ if rsp_valid arrives the same cycle.
- Buffer is empty when a response arrives: issue is gated by can_issue and only responses load the buffer. No overflow case exists.
- Redirect clears the buffer in the same edge (fetch_valid=0, instr_op=NOP_INSTR next cycle), regardless of stall. Redirect has priority over buffer load and consume.
- Buffer not loaded and consumed -> fetch_valid<=0, instr_op<=NOP_INSTR; pc_op/pc_incr_op hold their last values.
- redirect_pc[1:0] is forced to 2'b00 on load.
- fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Throughput: one instruction per 2 cycles with 0-wait memory (rsp the cycle after request).
- Latency: request at cycle N, response at N+1 -> fetch_valid at N+2.
- Reset asserted mid-request: the outstanding response is owned by the memory reset domain and is not tracked. After reset, state=REQ.

Decomposition:
- Shared cpu package holds:
  - NOP_INSTR constant (also used by Q1/Q2 reset).
  - fetch state encoding: REQ=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - XLEN=32 constant.
- One sub-module is natural: fetch_buf, a 1-entry holding register with load/consume/flush and NOP fill. The FSM and PC stay in fetch_unit.

Test Plan:
- Reset, ready=1, 0-wait memory returning addr^32'hA5A5_0000 -> requests 0x0,0x4,0x8. Outputs:
  - pc_op=0x0, instr_op=0xA5A5_0000, pc_incr_op=0x4, fetch_valid every other cycle.
  - instr_op=0x13 in bubbles.
- stall=1 for 5 cycles after the first valid fetch (pc 0x0) -> outputs frozen at 0x0. No second request issues until stall falls. The next fetch is pc 0x4; no instruction is skipped or duplicated.
- Redirect to 0x103 while in WAIT, response 2 cycles later -> response discarded. Next request address is 0x100. First valid output has pc_op=0x100, pc_incr_op=0x104.
- Redirect coincident with rsp_valid and with stall=1 holding a valid buffer -> buffer flushed (fetch_valid=0 next cycle), response dropped, next request address is redirect_pc.
- imem_req_ready held 0 for 3 cycles -> imem_req_valid and addr stay stable. Handshake on the 4th cycle. No duplicate request.
- RESET_PC=32'hFFFF_FFFC -> first fetch pc_op=0xFFFF_FFFC, pc_incr_op=0x0. Next request address is 0x0.
- rst asserted in WAIT -> outputs go to reset values immediately (asynchronously). First request after release is to RESET_PC.
